// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: base address,
// register offsets, serializer state encodings and the STATUS word layout.
package mmio_uart_tx_pkg;

   localparam logic [31:0] UART_BASE_ADDR = 32'h0000_1000;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef struct packed {
      logic [15:0] rsvdHi;
      logic [7:0]  count;
      logic [3:0]  rsvdLo;
      logic        ovf;
      logic        busy;
      logic        empty;
      logic        full;
   } status_t;

   // A divisor of zero would stall the bit timer, so it behaves as one cycle per bit.
   function automatic logic [15:0] effDiv(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART: address, store data, byte enables and
// combinational read data.
interface mmio_uart_tx_if;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;

   modport master (output daddr, output dwdata, output dwe, input drdata);
   modport slave  (input daddr, input dwdata, input dwe, output drdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with a combinational head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rdPtr;
   logic [AW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_count  = r_count;
   assign o_head   = r_mem[r_rdPtr];
   assign w_doPop  = i_pop & ~o_empty;
   assign w_doPush = i_push & (~o_full | w_doPop);

   always_ff @(posedge i_clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         if (w_doPush & ~w_doPop)      r_count <= r_count + 1'b1;
         else if (~w_doPush & w_doPop) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV registers on the CPU
// data bus, a byte FIFO and a serializer that sends frames back to back.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = UART_BASE_ADDR,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic           i_clk,
   input  logic           i_reset,
   mmio_uart_tx_if.slave  bus,
   output logic           o_tx,
   output logic           o_irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    r_state;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitIdx;
   logic [15:0]   r_cycCnt;
   logic [15:0]   r_div;
   logic          r_ovf;

   logic          w_sel;
   logic [1:0]    w_off;
   logic          w_wrEn;
   logic          w_push;
   logic          w_pop;
   logic          w_ovfClr;
   logic          w_divWr;
   logic          w_bitEnd;
   logic [15:0]   w_reload;
   logic [7:0]    w_head;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   status_t       w_status;
   logic          w_unused;

   assign w_sel    = (bus.daddr[31:4] == BASE_ADDR[31:4]);
   assign w_off    = bus.daddr[3:2];
   assign w_wrEn   = w_sel & (|bus.dwe);
   assign w_push   = w_wrEn & (w_off == OFF_TXDATA) & bus.dwe[0];
   assign w_ovfClr = w_wrEn & (w_off == OFF_STATUS) & bus.dwe[0] & bus.dwdata[3];
   assign w_divWr  = w_wrEn & (w_off == OFF_DIV);
   assign w_bitEnd = (r_cycCnt == 16'd0);
   assign w_reload = effDiv(r_div) - 16'd1;
   assign w_unused = ^{bus.daddr[1:0], bus.dwdata[31:16], bus.dwe[3:2]};

   // The serializer takes a byte either from idle or at the last cycle of a stop bit.
   assign w_pop = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bitEnd));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_data  (bus.dwdata[7:0]),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ovf <= 1'b0;
         r_div <= DIV_RESET;
      end else begin
         if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
         else if (w_ovfClr)            r_ovf <= 1'b0;
         if (w_divWr & bus.dwe[0]) r_div[7:0]  <= bus.dwdata[7:0];
         if (w_divWr & bus.dwe[1]) r_div[15:8] <= bus.dwdata[15:8];
      end
   end

   // Bit timer reloads from DIV at every bit start, so DIV changes land on the next bit.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_shift  <= '0;
         r_bitIdx <= '0;
         r_cycCnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_state  <= ST_START;
                  r_shift  <= w_head;
                  r_cycCnt <= w_reload;
               end
            end
            ST_START: begin
               if (w_bitEnd) begin
                  r_state  <= ST_DATA;
                  r_bitIdx <= '0;
                  r_cycCnt <= w_reload;
               end else begin
                  r_cycCnt <= r_cycCnt - 16'd1;
               end
            end
            ST_DATA: begin
               if (w_bitEnd) begin
                  r_cycCnt <= w_reload;
                  r_shift  <= {1'b0, r_shift[7:1]};
                  if (r_bitIdx == 3'd7) r_state <= ST_STOP;
                  else                  r_bitIdx <= r_bitIdx + 3'd1;
               end else begin
                  r_cycCnt <= r_cycCnt - 16'd1;
               end
            end
            ST_STOP: begin
               if (w_bitEnd) begin
                  if (w_pop) begin
                     r_state  <= ST_START;
                     r_shift  <= w_head;
                     r_cycCnt <= w_reload;
                  end else begin
                     r_state  <= ST_IDLE;
                  end
               end else begin
                  r_cycCnt <= r_cycCnt - 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_tx = 1'b1;
      case (r_state)
         ST_START: o_tx = 1'b0;
         ST_DATA:  o_tx = r_shift[0];
         default:  o_tx = 1'b1;
      endcase
   end

   assign o_irq = w_empty & (r_state == ST_IDLE);

   always_comb begin
      w_status       = '0;
      w_status.count = 8'(w_count);
      w_status.ovf   = r_ovf;
      w_status.busy  = (r_state != ST_IDLE);
      w_status.empty = w_empty;
      w_status.full  = w_full;
      bus.drdata     = 32'd0;
      if (w_sel) begin
         case (w_off)
            OFF_STATUS: bus.drdata = w_status;
            OFF_DIV:    bus.drdata = {16'd0, r_div};
            default:    bus.drdata = 32'd0;
         endcase
      end
   end

endmodule
